// File: rtl/spike_aer_pkg.sv
// spike_aer_pkg
// Types and sizing helpers shared by the AER transmitter, its bus interface
// and the bench.
//   aer_tx_state_e : transmitter FSM state, also exported on the debug port
//   aer_aw()       : address width for a population of n neurons
//   aer_wcw()      : width of a wait counter that has to reach a given limit
package spike_aer_pkg;

  localparam int N_DEFAULT = 256;

  function automatic int aer_aw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // The counter must be able to hold the limit itself.
  function automatic int aer_wcw(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

  localparam int AW_DEFAULT = aer_aw(N_DEFAULT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    REQ_HI = 3'd3,
    REQ_LO = 3'd4
  } aer_tx_state_e;

endpackage

// File: rtl/spike_aer_tx_if.sv
// spike_aer_tx_if
// Bundles the spike FIFO read port and the AEROUT pad signals of the
// transmitter.
//   fifo_empty_i   FIFO empty flag
//   fifo_r_en_o    FIFO read enable (one-cycle pulse)
//   fifo_r_data_i  FIFO read data
//   AEROUT_ADDR_o  AER address, bundled with REQ
//   AEROUT_REQ_o   AER request
//   AEROUT_ACK_i   AER acknowledge (asynchronous)
//
// Handshake semantics:
//   FIFO side: fifo_r_en_o is only raised when fifo_empty_i was low, and
//   fifo_r_data_i is taken exactly one cycle after the fifo_r_en_o pulse.
//   AER side: 4-phase. AEROUT_ADDR_o is stable before REQ rises and stays
//   stable until ACK has fallen; REQ rises, ACK rises, REQ falls, ACK
//   falls, and only then may a new REQ rise.
interface spike_aer_tx_if
  import spike_aer_pkg::*;
#(
  parameter int AW = AW_DEFAULT
);
  logic          fifo_empty_i;
  logic          fifo_r_en_o;
  logic [AW-1:0] fifo_r_data_i;
  logic [AW-1:0] AEROUT_ADDR_o;
  logic          AEROUT_REQ_o;
  logic          AEROUT_ACK_i;

  // Transmitter side.
  modport master (
    input  fifo_empty_i,
    input  fifo_r_data_i,
    input  AEROUT_ACK_i,
    output fifo_r_en_o,
    output AEROUT_ADDR_o,
    output AEROUT_REQ_o
  );

  // FIFO and off-chip receiver side.
  modport slave (
    output fifo_empty_i,
    output fifo_r_data_i,
    output AEROUT_ACK_i,
    input  fifo_r_en_o,
    input  AEROUT_ADDR_o,
    input  AEROUT_REQ_o
  );
endinterface

// File: rtl/spike_aer_tx_sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for signals asynchronous to CLK; q lags d by two
// clock cycles. Reset clears both stages to 0.
//   CLK   clock
//   RSTN  asynchronous active-low reset
//   d     asynchronous input
//   q     synchronised output
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end
endmodule

// File: rtl/spike_aer_tx.sv
// spike_aer_tx
// Pops neuron addresses from the spike FIFO and sends each one off-chip
// over a 4-phase bundled-data AER handshake, with an ACK timeout.
//   CLK, RSTN      clock, asynchronous active-low reset
//   enable_i       allows new pops; an event already in flight completes
//   aer            FIFO read port + AEROUT pads (spike_aer_tx_if.master)
//   busy_o         high whenever the FSM is not in IDLE
//   timeout_err_o  sticky, set on the first ACK timeout
//   sent_cnt_o     completed events, wraps
//   drop_cnt_o     timed-out events, saturates at all-ones
//   state_o        current FSM state (debug)
module spike_aer_tx
  import spike_aer_pkg::*;
#(
  parameter int          N           = 256,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int          CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             enable_i,
  spike_aer_tx_if.master   aer,
  output logic             busy_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] sent_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output aer_tx_state_e    state_o
);
  localparam int AW  = aer_aw(N);
  localparam int WCW = aer_wcw(ACK_TIMEOUT);

  aer_tx_state_e    state_q, state_d;
  logic [WCW-1:0]   wait_q;
  logic [AW-1:0]    addr_q;
  logic             req_q;
  logic             err_q;
  logic [CNT_W-1:0] sent_q;
  logic [CNT_W-1:0] drop_q;
  logic             ack_s;
  logic             timeout_hit;
  logic             wait_clr, load_addr, sent_inc, drop_inc, err_set;

  sync_2ff #(.W(1)) u_ack_sync (
    .CLK  (CLK),
    .RSTN (RSTN),
    .d    (aer.AEROUT_ACK_i),
    .q    (ack_s)
  );

  // The wait counter is 0 in the first cycle of REQ_HI/REQ_LO, so the limit
  // is reached after ACK_TIMEOUT further cycles. In REQ_HI that is exactly
  // the number of cycles REQ is high, since REQ rises one cycle after entry.
  assign timeout_hit = (ACK_TIMEOUT != 0) && (32'(wait_q) == ACK_TIMEOUT);

  always_comb begin
    state_d   = state_q;
    wait_clr  = 1'b0;
    load_addr = 1'b0;
    sent_inc  = 1'b0;
    drop_inc  = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i && !aer.fifo_empty_i) state_d = POP;
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        load_addr = 1'b1;
        wait_clr  = 1'b1;
        state_d   = REQ_HI;
      end
      REQ_HI: begin
        // ACK only counts once REQ is actually up, so a stale ACK cannot
        // complete an event that was never requested. ACK wins over timeout.
        if (req_q && ack_s) begin
          sent_inc = 1'b1;
          wait_clr = 1'b1;
          state_d  = REQ_LO;
        end else if (timeout_hit) begin
          drop_inc = 1'b1;
          err_set  = 1'b1;
          wait_clr = 1'b1;
          state_d  = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          err_set = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      sent_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      if (wait_clr) begin
        wait_q <= '0;
      end else if (state_q == REQ_HI || state_q == REQ_LO) begin
        wait_q <= wait_q + WCW'(1);
      end
      if (load_addr) addr_q <= aer.fifo_r_data_i;
      // REQ comes up one cycle after the address register loads (setup
      // margin) and falls on the edge that leaves REQ_HI.
      req_q <= (state_q == REQ_HI) && (state_d == REQ_HI);
      if (err_set) err_q <= 1'b1;
      if (sent_inc) sent_q <= sent_q + CNT_W'(1);
      if (drop_inc && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign aer.fifo_r_en_o   = (state_q == POP);
  assign aer.AEROUT_ADDR_o = addr_q;
  assign aer.AEROUT_REQ_o  = req_q;
  assign busy_o            = (state_q != IDLE);
  assign timeout_err_o     = err_q;
  assign sent_cnt_o        = sent_q;
  assign drop_cnt_o        = drop_q;
  assign state_o           = state_q;
endmodule

// File: tb/tb_spike_aer_tx.sv
// tb_spike_aer_tx
// Directed bench for spike_aer_tx with ACK_TIMEOUT=8 and CNT_W=2. A FIFO
// model and a 4-phase responder (3-cycle ACK delay in both phases) run in
// the tick task; addresses are scoreboarded against exp_q at each REQ rise.
module tb_spike_aer_tx;
  import spike_aer_pkg::*;

  localparam int AW  = 8;
  localparam int TMO = 8;
  localparam int CW  = 2;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          enable;
  logic          busy;
  logic          err;
  logic [CW-1:0] sent;
  logic [CW-1:0] drop;
  aer_tx_state_e state;

  spike_aer_tx_if #(.AW(AW)) bus ();

  spike_aer_tx #(.N(256), .ACK_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .CLK           (CLK),
    .RSTN          (RSTN),
    .enable_i      (enable),
    .aer           (bus),
    .busy_o        (busy),
    .timeout_err_o (err),
    .sent_cnt_o    (sent),
    .drop_cnt_o    (drop),
    .state_o       (state)
  );

  always #5 CLK = ~CLK;

  logic [AW-1:0] fifo_q[$];
  logic [AW-1:0] exp_q[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            ren_cnt  = 0;
  int            rd_empty_err = 0;
  int            stab_err = 0;
  int            req_len  = 0;
  int            last_req_len = 0;
  int            rsp_cnt  = 0;
  int            ren0     = 0;
  logic          ack_auto = 1'b0;
  logic          req_prev = 1'b0;
  logic          in_txn   = 1'b0;
  logic [AW-1:0] addr_prev = '0;
  logic [AW-1:0] held_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a);
    fifo_q.push_back(a);
    exp_q.push_back(a);
    bus.fifo_empty_i = 1'b0;
  endtask

  // One clock cycle: FIFO model, ACK responder, monitor/scoreboard.
  task automatic tick();
    logic          ren_seen;
    logic [AW-1:0] e;
    @(negedge CLK);
    ren_seen = bus.fifo_r_en_o;
    if (ren_seen) begin
      ren_cnt++;
      if (bus.fifo_empty_i) rd_empty_err++;
    end
    @(posedge CLK);
    #1;
    if (ren_seen && fifo_q.size() > 0) bus.fifo_r_data_i = fifo_q.pop_front();
    bus.fifo_empty_i = (fifo_q.size() == 0);
    if (!ack_auto) begin
      bus.AEROUT_ACK_i = 1'b0;
      rsp_cnt = 0;
    end else if (bus.AEROUT_REQ_o != bus.AEROUT_ACK_i) begin
      rsp_cnt++;
      if (rsp_cnt == 3) begin
        bus.AEROUT_ACK_i = bus.AEROUT_REQ_o;
        rsp_cnt = 0;
      end
    end else begin
      rsp_cnt = 0;
    end
    if (bus.AEROUT_REQ_o && !req_prev) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("addr_at_req", 32'(bus.AEROUT_ADDR_o), 32'(e));
      check("addr_setup", 32'(addr_prev), 32'(e));
      held_addr = bus.AEROUT_ADDR_o;
      in_txn = 1'b1;
    end
    if (!bus.AEROUT_REQ_o && !bus.AEROUT_ACK_i) in_txn = 1'b0;
    if (in_txn && bus.AEROUT_ADDR_o != held_addr) stab_err++;
    if (bus.AEROUT_REQ_o) begin
      req_len++;
    end else if (req_prev) begin
      last_req_len = req_len;
      req_len = 0;
    end
    req_prev  = bus.AEROUT_REQ_o;
    addr_prev = bus.AEROUT_ADDR_o;
  endtask

  initial begin
    RSTN = 1'b0;
    enable = 1'b0;
    bus.fifo_empty_i  = 1'b1;
    bus.fifo_r_data_i = '0;
    bus.AEROUT_ACK_i  = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_req", 32'(bus.AEROUT_REQ_o), 0);
    check("rst_addr", 32'(bus.AEROUT_ADDR_o), 0);
    check("rst_ren", 32'(bus.fifo_r_en_o), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_sent", 32'(sent), 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_state", 32'(state), 32'(IDLE));
    RSTN = 1'b1;
    tick();

    // Two normal handshakes: 0x12 then 0x34
    ack_auto = 1'b1;
    push(8'h12);
    push(8'h34);
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy && fifo_q.size() == 0 && exp_q.size() == 0) break;
    end
    check("t1_busy", 32'(busy), 0);
    check("t1_exp_left", exp_q.size(), 0);
    check("t1_sent", 32'(sent), 2);
    check("t1_ren_pulses", ren_cnt, 2);
    check("t1_fifo_empty", 32'(bus.fifo_empty_i), 1);
    check("t1_req_len", last_req_len, 5);
    check("t1_addr_hold", 32'(bus.AEROUT_ADDR_o), 32'h34);
    check("t1_drop", 32'(drop), 0);

    // ACK never comes: REQ high 8 cycles, then drop
    ack_auto = 1'b0;
    push(8'h56);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (err) break;
    end
    check("t2_err", 32'(err), 1);
    check("t2_drop", 32'(drop), 1);
    check("t2_sent", 32'(sent), 2);
    check("t2_req_len", last_req_len, 8);
    check("t2_req_low", 32'(bus.AEROUT_REQ_o), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!busy) break;
    end
    check("t2_idle", 32'(busy), 0);

    // Next event after a timeout goes through normally
    ack_auto = 1'b1;
    push(8'h78);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy && exp_q.size() == 0) break;
    end
    check("t2b_sent", 32'(sent), 3);
    check("t2b_drop", 32'(drop), 1);
    check("t2b_err_sticky", 32'(err), 1);
    check("t2b_req_len", last_req_len, 5);

    // enable low with a non-empty FIFO: no pops
    enable = 1'b0;
    push(8'h9A);
    ren0 = ren_cnt;
    repeat (20) tick();
    check("t3_no_pop", ren_cnt, ren0);
    check("t3_busy", 32'(busy), 0);
    check("t3_fifo_lvl", fifo_q.size(), 1);

    // Drop enable during REQ_HI: event completes, sent wraps 3 -> 0
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.AEROUT_REQ_o) break;
    end
    check("t3_req_up", 32'(bus.AEROUT_REQ_o), 1);
    push(8'hBC);
    enable = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!busy) break;
    end
    check("t3_done", 32'(busy), 0);
    check("t3_sent_wrap", 32'(sent), 0);
    check("t3_one_pop", ren_cnt, ren0 + 1);
    repeat (10) tick();
    check("t3_no_more_pop", ren_cnt, ren0 + 1);
    check("t3_fifo_kept", fifo_q.size(), 1);

    // Three more timeouts (four total): drop saturates at 3
    ack_auto = 1'b0;
    push(8'hC1);
    push(8'hC2);
    enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!busy && fifo_q.size() == 0 && exp_q.size() == 0) break;
    end
    check("t4_busy", 32'(busy), 0);
    check("t4_drop_sat", 32'(drop), 3);
    check("t4_sent", 32'(sent), 0);
    check("t4_req_len", last_req_len, 8);

    // Reset while REQ is high
    ack_auto = 1'b1;
    push(8'hDE);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.AEROUT_REQ_o) break;
    end
    check("t5_req_up", 32'(bus.AEROUT_REQ_o), 1);
    ack_auto = 1'b0;
    bus.AEROUT_ACK_i = 1'b0;
    RSTN = 1'b0;
    #1;
    check("t5_req", 32'(bus.AEROUT_REQ_o), 0);
    check("t5_addr", 32'(bus.AEROUT_ADDR_o), 0);
    check("t5_err", 32'(err), 0);
    check("t5_drop", 32'(drop), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_state", 32'(state), 32'(IDLE));
    enable = 1'b0;
    repeat (2) tick();
    RSTN = 1'b1;
    repeat (3) tick();
    check("t5_state_rel", 32'(state), 32'(IDLE));
    check("t5_req_rel", 32'(bus.AEROUT_REQ_o), 0);

    // Recovery after reset
    ack_auto = 1'b1;
    push(8'hEF);
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy && exp_q.size() == 0) break;
    end
    check("t6_sent", 32'(sent), 1);
    check("t6_addr", 32'(bus.AEROUT_ADDR_o), 32'hEF);
    check("rd_while_empty", rd_empty_err, 0);
    check("addr_stability", stab_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
